// File: rtl/switch_input_port_5x80.sv
// Switch input port: flit FIFO with head-flit validation, packet lock FSM and
// sticky error flags. The FIFO head is broadcast to every output allocator.
module switch_input_port_5x80 #(
   parameter int DEPTH = 4,
   parameter int NOUT  = 5,
   parameter int FLITW = 80
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [FLITW-1:0] flit_in,
   input  logic             valid_in,
   output logic             busy_out,
   output logic [FLITW-1:0] flit_out,
   output logic             valid_out,
   input  logic [NOUT-1:0]  not_accept_in,
   output logic [2:0]       cur_port,
   output logic             in_packet,
   output logic [2:0]       err_flags
);

   localparam int             AW       = $clog2(DEPTH);
   localparam logic [AW:0]    FULL_CNT = (AW+1)'(DEPTH);
   localparam logic [31:0]    NOUT_U   = 32'(NOUT);

   localparam logic [1:0]     T_HEAD    = 2'b00;
   localparam logic [1:0]     T_PAYLOAD = 2'b01;
   localparam logic [1:0]     T_TAIL    = 2'b10;
   localparam logic [1:0]     T_SINGLE  = 2'b11;

   localparam logic [0:0]     S_IDLE = 1'b0;
   localparam logic [0:0]     S_PKT  = 1'b1;

   logic [FLITW-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q, count_d;
   logic [0:0]       state_q, state_d;
   logic [2:0]       cur_port_q, cur_port_d;
   logic [2:0]       err_q, err_d;

   logic [FLITW-1:0] head_flit;
   logic [1:0]       ftype;
   logic [2:0]       fdest;
   logic             nonempty, full;
   logic             is_hs, legal, in_range;
   logic             accept, discard, push, pop;

   // Head decode uses registered state only, so busy_out has no input path.
   always_comb begin
      head_flit = mem_q[rd_ptr_q];
      ftype     = head_flit[1:0];
      fdest     = head_flit[4:2];
      nonempty  = (count_q != '0);
      full      = (count_q == FULL_CNT);
      is_hs     = (ftype == T_HEAD) || (ftype == T_SINGLE);
      legal     = (state_q == S_IDLE) ? is_hs : !is_hs;
      in_range  = !is_hs || ({29'd0, fdest} < NOUT_U);
      valid_out = nonempty && legal && in_range;
      accept    = valid_out && (not_accept_in == '0);
      discard   = nonempty && !(legal && in_range);
      push      = valid_in && !full;
      pop       = accept || discard;
   end

   // NOTE: every signal assigned here gets a default first, so no latch is inferred.
   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      state_d    = state_q;
      cur_port_d = cur_port_q;
      err_d      = err_q;

      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);

      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase

      // Only accepted flits advance the packet lock; discards leave it alone.
      if (accept) begin
         case (ftype)
            T_HEAD: begin
               state_d    = S_PKT;
               cur_port_d = fdest;
            end
            T_TAIL:    state_d = S_IDLE;
            T_PAYLOAD: state_d = S_PKT;
            default:   state_d = state_q;
         endcase
      end

      err_d = err_q | {nonempty && !in_range,
                       nonempty && !legal,
                       valid_in && full};
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         state_q    <= S_IDLE;
         cur_port_q <= '0;
         err_q      <= '0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         state_q    <= state_d;
         cur_port_q <= cur_port_d;
         err_q      <= err_d;
      end
   end

   // NOTE: storage is not reset; count_q gates every read, so stale entries are never seen.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= flit_in;
   end

   assign busy_out  = full;
   assign flit_out  = head_flit;
   assign cur_port  = cur_port_q;
   assign in_packet = (state_q == S_PKT);
   assign err_flags = err_q;

endmodule

// File: tb/tb_switch_input_port_5x80.sv
// Directed bench for switch_input_port_5x80: accepted flits are checked in order
// against a scoreboard queue filled when the stimulus is driven.
module tb_switch_input_port_5x80;

   logic        clk = 1'b0;
   logic        rst;
   logic [79:0] flit_in;
   logic        valid_in;
   logic        busy_out;
   logic [79:0] flit_out;
   logic        valid_out;
   logic [4:0]  not_accept_in;
   logic [2:0]  cur_port;
   logic        in_packet;
   logic [2:0]  err_flags;

   int total = 0;
   int bad   = 0;
   logic [79:0] sb [$];
   logic [79:0] held;

   always #5 clk = ~clk;

   switch_input_port_5x80 dut (
      .clk           (clk),
      .rst           (rst),
      .flit_in       (flit_in),
      .valid_in      (valid_in),
      .busy_out      (busy_out),
      .flit_out      (flit_out),
      .valid_out     (valid_out),
      .not_accept_in (not_accept_in),
      .cur_port      (cur_port),
      .in_packet     (in_packet),
      .err_flags     (err_flags)
   );

   task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [79:0] mk(input logic [1:0] t, input logic [2:0] d, input logic [7:0] id);
      return {8'hC3, 67'(id), d, t};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Every accepted flit must be the oldest expected one.
   always @(negedge clk) begin
      if (!rst && valid_out && not_accept_in == 5'b0) begin
         if (sb.size() == 0) begin
            total++;
            bad++;
            $error("FAIL sb_unexpected observed=%0h expected=none", flit_out);
         end else begin
            check("sb_flit", flit_out, sb.pop_front());
         end
      end
   end

   initial begin
      rst           = 1'b1;
      valid_in      = 1'b0;
      flit_in       = '0;
      not_accept_in = '0;
      repeat (2) tick();
      rst = 1'b0;
      check("rst_busy",     80'(busy_out),  80'(0));
      check("rst_valid",    80'(valid_out), 80'(0));
      check("rst_inpkt",    80'(in_packet), 80'(0));
      check("rst_err",      80'(err_flags), 80'(0));
      check("rst_curport",  80'(cur_port),  80'(0));

      // Head(3), payload, tail on consecutive cycles, all accepted.
      flit_in = mk(2'b00, 3'd3, 8'h01); valid_in = 1'b1; sb.push_back(flit_in);
      #1 check("nofallthru", 80'(valid_out), 80'(0));
      tick();
      check("pkt_v_c2", 80'(valid_out), 80'(1));
      flit_in = mk(2'b01, 3'd0, 8'h02); sb.push_back(flit_in);
      tick();
      check("pkt_inpkt_c3", 80'(in_packet), 80'(1));
      check("pkt_curport",  80'(cur_port),  80'(3));
      check("pkt_v_c3",     80'(valid_out), 80'(1));
      flit_in = mk(2'b10, 3'd0, 8'h03); sb.push_back(flit_in);
      tick();
      valid_in = 1'b0;
      check("pkt_v_c4",     80'(valid_out), 80'(1));
      check("pkt_inpkt_c4", 80'(in_packet), 80'(1));
      tick();
      check("pkt_inpkt_end", 80'(in_packet), 80'(0));
      check("pkt_v_end",     80'(valid_out), 80'(0));

      // Fill with four singles while output 3 refuses, then overflow.
      not_accept_in = 5'b01000;
      for (int i = 0; i < 4; i++) begin
         flit_in = mk(2'b11, 3'(i), 8'h10 + 8'(i)); valid_in = 1'b1; sb.push_back(flit_in);
         tick();
         if (i == 2) check("busy_3", 80'(busy_out), 80'(0));
      end
      check("busy_full", 80'(busy_out), 80'(1));
      held = flit_out;
      check("full_head", flit_out, mk(2'b11, 3'd0, 8'h10));
      flit_in = mk(2'b11, 3'd1, 8'h1F);
      tick();
      check("ovf_err",    80'(err_flags), 80'(3'b001));
      check("ovf_stable", flit_out, held);
      check("ovf_valid",  80'(valid_out), 80'(1));
      check("ovf_busy",   80'(busy_out),  80'(1));

      // Full FIFO: pop together with a push that must be dropped.
      flit_in = mk(2'b11, 3'd2, 8'h2F); not_accept_in = 5'b0;
      #1 check("popfull_busy", 80'(busy_out), 80'(1));
      tick();
      valid_in = 1'b0;
      check("popfull_err", 80'(err_flags), 80'(3'b001));
      repeat (3) tick();
      check("drain_valid", 80'(valid_out), 80'(0));
      check("drain_busy",  80'(busy_out),  80'(0));
      check("drain_sb",    80'(sb.size()), 80'(0));

      // Payload while IDLE: never presented, discarded, protocol error.
      flit_in = mk(2'b01, 3'd0, 8'h30); valid_in = 1'b1;
      tick();
      valid_in = 1'b0;
      check("proto_valid", 80'(valid_out), 80'(0));
      tick();
      check("proto_err",   80'(err_flags), 80'(3'b011));
      check("proto_idle",  80'(in_packet), 80'(0));
      check("proto_empty", 80'(valid_out), 80'(0));

      // Single to port 6 is out of range; single to port 1 goes through.
      flit_in = mk(2'b11, 3'd6, 8'h40); valid_in = 1'b1;
      tick();
      check("route_valid", 80'(valid_out), 80'(0));
      flit_in = mk(2'b11, 3'd1, 8'h41); sb.push_back(flit_in);
      tick();
      valid_in = 1'b0;
      check("route_err",  80'(err_flags), 80'(3'b111));
      check("route_next", 80'(valid_out), 80'(1));
      check("route_inpk", 80'(in_packet), 80'(0));
      tick();
      check("single_done", 80'(valid_out), 80'(0));
      check("single_inpk", 80'(in_packet), 80'(0));

      // Reset mid-packet with three flits buffered.
      flit_in = mk(2'b00, 3'd2, 8'h50); valid_in = 1'b1; sb.push_back(flit_in);
      tick();
      flit_in = mk(2'b01, 3'd0, 8'h51);
      tick();
      not_accept_in = 5'b00001;
      check("mid_curport", 80'(cur_port), 80'(2));
      flit_in = mk(2'b01, 3'd0, 8'h52);
      tick();
      flit_in = mk(2'b01, 3'd0, 8'h53);
      tick();
      valid_in = 1'b0;
      check("mid_inpkt", 80'(in_packet), 80'(1));
      check("mid_valid", 80'(valid_out), 80'(1));
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("mrst_valid",   80'(valid_out), 80'(0));
      check("mrst_inpkt",   80'(in_packet), 80'(0));
      check("mrst_err",     80'(err_flags), 80'(0));
      check("mrst_busy",    80'(busy_out),  80'(0));
      check("mrst_curport", 80'(cur_port),  80'(0));
      not_accept_in = 5'b0;
      tick();
      check("mrst_stay",  80'(valid_out), 80'(0));
      check("final_sb",   80'(sb.size()), 80'(0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
